// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen
//   Synthetic video source. It produces two cycle-aligned DVP-style streams:
//   an RGB565 gradient with a solid orange box, and an 8-bit skin mask that
//   is 8'hFF inside the same box. The box bounces across the frame by STEP
//   pixels in x and y at each frame end while move_en is high.
//
// Ports
//   clk, rst           pixel clock, synchronous active-high reset
//   en                 run request (level); a frame is never truncated
//   move_en            box advances at frame end when high
//   RGB_*              RGB stream: hsync = de = active, vsync high on active lines
//   face_*             mask stream, with syncs identical to the RGB ones
//   box_x, box_y       top-left corner of the box in the frame being output
//   busy               high while running (aligned with the stream outputs)
//   frame_done         one-cycle pulse on the last output cycle of each frame
//
// All outputs are registered and lag the internal counters by one cycle.

module vid_pattern_gen #(
    parameter logic [11:0] H_DISP  = 12'd480,
    parameter logic [11:0] V_DISP  = 12'd272,
    parameter logic [11:0] H_BLANK = 12'd40,
    parameter logic [11:0] V_BLANK = 12'd8,
    parameter logic [11:0] BOX_W   = 12'd64,
    parameter logic [11:0] BOX_H   = 12'd48,
    parameter logic [11:0] STEP    = 12'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        move_en,
    output logic        RGB_hsync,
    output logic        RGB_vsync,
    output logic        RGB_de,
    output logic [15:0] RGB_data,
    output logic        face_hsync,
    output logic        face_vsync,
    output logic        face_de,
    output logic [7:0]  face_data,
    output logic [11:0] box_x,
    output logic [11:0] box_y,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [11:0] H_LAST = H_DISP + H_BLANK - 12'd1;
    localparam logic [11:0] V_LAST = V_DISP + V_BLANK - 12'd1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] pos_x_q, pos_x_d;
    logic [11:0] pos_y_q, pos_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;

    // Output registers. hsync and de are the same signal, so one flop drives both.
    logic        de_q, de_d;
    logic        vsync_q, vsync_d;
    logic [15:0] rgb_q, rgb_d;
    logic [7:0]  face_q, face_d;
    logic [11:0] box_x_q, box_x_d;
    logic [11:0] box_y_q, box_y_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic running, frame_end, line_active, active, inbox;

    assign running     = (state_q == RUN);
    assign frame_end   = running && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    assign line_active = running && (v_cnt_q < V_DISP);
    assign active      = line_active && (h_cnt_q < H_DISP);
    assign inbox       = active
                       && (h_cnt_q >= pos_x_q) && (h_cnt_q <= pos_x_q + BOX_W - 12'd1)
                       && (v_cnt_q >= pos_y_q) && (v_cnt_q <= pos_y_q + BOX_H - 12'd1);

    // FSM, raster counters and box motion.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;

        unique case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 12'd1;
                end
                // en is only honoured at frame end so frames are never cut short.
                if (frame_end && !en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The box bounces: when the next step would leave the active area it
        // is clamped to the edge and the direction flips for the next frame.
        if (frame_end && move_en) begin
            if (dir_x_q) begin
                if (pos_x_q + BOX_W + STEP > H_DISP) begin
                    pos_x_d = H_DISP - BOX_W;
                    dir_x_d = 1'b0;
                end else begin
                    pos_x_d = pos_x_q + STEP;
                end
            end else begin
                if (pos_x_q < STEP) begin
                    pos_x_d = '0;
                    dir_x_d = 1'b1;
                end else begin
                    pos_x_d = pos_x_q - STEP;
                end
            end

            if (dir_y_q) begin
                if (pos_y_q + BOX_H + STEP > V_DISP) begin
                    pos_y_d = V_DISP - BOX_H;
                    dir_y_d = 1'b0;
                end else begin
                    pos_y_d = pos_y_q + STEP;
                end
            end else begin
                if (pos_y_q < STEP) begin
                    pos_y_d = '0;
                    dir_y_d = 1'b1;
                end else begin
                    pos_y_d = pos_y_q - STEP;
                end
            end
        end
    end

    // Stream outputs, computed from the current counters and registered.
    always_comb begin
        de_d         = active;
        vsync_d      = line_active;
        face_d       = inbox ? 8'hFF : 8'h00;
        rgb_d        = 16'h0000;
        if (inbox) begin
            rgb_d = 16'hFD20;
        end else if (active) begin
            rgb_d = {h_cnt_q[7:3], v_cnt_q[7:2], h_cnt_q[7:3]};
        end
        // The box copy lags the position register by one cycle so it changes
        // together with the first pixel of the frame that uses it.
        box_x_d      = pos_x_q;
        box_y_d      = pos_y_q;
        busy_d       = running;
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            state_q      <= IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
            de_q         <= 1'b0;
            vsync_q      <= 1'b0;
            rgb_q        <= '0;
            face_q       <= '0;
            box_x_q      <= '0;
            box_y_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            de_q         <= de_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
            face_q       <= face_d;
            box_x_q      <= box_x_d;
            box_y_q      <= box_y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign RGB_hsync  = de_q;
    assign RGB_de     = de_q;
    assign RGB_vsync  = vsync_q;
    assign RGB_data   = rgb_q;
    assign face_hsync = de_q;
    assign face_de    = de_q;
    assign face_vsync = vsync_q;
    assign face_data  = face_q;
    assign box_x      = box_x_q;
    assign box_y      = box_y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
